// File: rtl/riscv_pc_pkg.sv
// Shared definitions for the PC sequencer: B-type condition codes and
// the two-state stall/redirect FSM encoding.
package riscv_pc_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } pc_state_e;

endpackage

// File: rtl/branch_cond.sv
// Decodes the B-type funct3 against the ALU comparison flags into a single
// branch-condition bit.
module branch_cond
  import riscv_pc_pkg::*;
(
  input  logic [2:0] branch_op,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       cond
);

  // Reserved funct3 codes 010/011 never branch.
  always_comb begin
    cond = 1'b0;
    case (branch_op)
      BR_BEQ:  cond = zero;
      BR_BNE:  cond = ~zero;
      BR_BLT:  cond = lt;
      BR_BGE:  cond = ~lt;
      BR_BLTU: cond = ltu;
      BR_BGEU: cond = ~ltu;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection, stall handling with a
// one-entry pending redirect, misaligned-target trap and redirect counter.
module pc_sequencer
  import riscv_pc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_PC  = XLEN'(32'h0000_0100),
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic [2:0]       branch_op,
  input  logic             jump,
  input  logic             jalr,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             taken,
  output logic             misaligned,
  output logic             pending,
  output logic [CNT_W-1:0] taken_count
);

  pc_state_e        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
  logic             pend_trap_q, pend_trap_d;
  logic             pending_q, pending_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             cond;
  logic [XLEN-1:0]  jalr_sum;
  logic [XLEN-1:0]  jalr_target;
  logic [XLEN-1:0]  br_target;
  logic [XLEN-1:0]  target;
  logic             trap;
  logic [CNT_W-1:0] cnt_sat;

  branch_cond u_branch_cond (
    .branch_op (branch_op),
    .zero      (zero),
    .lt        (lt),
    .ltu       (ltu),
    .cond      (cond)
  );

  // JALR clears bit 0, so only bit 1 can make its target misaligned.
  assign jalr_sum    = rs1 + imm;
  assign jalr_target = jalr_sum & ~XLEN'(1);
  assign br_target   = pc_q + imm;
  assign target      = jalr ? jalr_target : br_target;
  assign taken       = jalr | jump | (branch & cond);
  assign trap        = taken & (target[1:0] != 2'b00);
  assign pc_plus4    = pc_q + XLEN'(4);
  assign cnt_sat     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    pend_trap_d = pend_trap_q;
    pending_d   = pending_q;
    mis_d       = 1'b0;
    cnt_d       = cnt_q;
    case (state_q)
      RUN: begin
        if (!stall) begin
          if (trap) begin
            pc_d  = TRAP_PC;
            mis_d = 1'b1;
          end else if (taken) begin
            pc_d  = target;
            cnt_d = cnt_sat;
          end else begin
            pc_d = pc_plus4;
          end
        end else if (taken) begin
          pend_pc_d   = trap ? TRAP_PC : target;
          pend_trap_d = trap;
          pending_d   = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        // Decisions arriving while held are dropped; only the buffered one applies.
        if (!stall) begin
          pc_d      = pend_pc_q;
          mis_d     = pend_trap_q;
          pending_d = 1'b0;
          state_d   = RUN;
          if (!pend_trap_q) cnt_d = cnt_sat;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      pend_pc_q   <= '0;
      pend_trap_q <= 1'b0;
      pending_q   <= 1'b0;
      mis_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      pend_trap_q <= pend_trap_d;
      pending_q   <= pending_d;
      mis_q       <= mis_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign misaligned  = mis_q;
  assign pending     = pending_q;
  assign taken_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// stimulus against a behavioural next-PC model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] TRP_PC  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset, stall, branch, jump, jalr, zero, lt, ltu;
  logic [2:0]  branch_op;
  logic [31:0] imm, rs1;

  logic [31:0] pc, pc_plus4;
  logic        taken, misaligned, pending;
  logic [15:0] taken_count;

  logic [31:0] pc_b, pc_plus4_b;
  logic        taken_b, misaligned_b, pending_b;
  logic [1:0]  count_b;

  int checks = 0;
  int passes = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_buf_pc;
  bit          m_hold, m_buf_trap, m_mis;
  int          m_cnt, m_cnt2;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .branch_op(branch_op),
    .jump(jump), .jalr(jalr), .zero(zero), .lt(lt), .ltu(ltu), .imm(imm), .rs1(rs1),
    .pc(pc), .pc_plus4(pc_plus4), .taken(taken), .misaligned(misaligned),
    .pending(pending), .taken_count(taken_count)
  );

  pc_sequencer #(.CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .branch_op(branch_op),
    .jump(jump), .jalr(jalr), .zero(zero), .lt(lt), .ltu(ltu), .imm(imm), .rs1(rs1),
    .pc(pc_b), .pc_plus4(pc_plus4_b), .taken(taken_b), .misaligned(misaligned_b),
    .pending(pending_b), .taken_count(count_b)
  );

  always #5 clk = ~clk;

  function automatic bit m_cond();
    case (branch_op)
      3'd0: return zero;
      3'd1: return !zero;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_taken();
    return jalr || jump || (branch && m_cond());
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] s;
    if (jalr) begin
      s = rs1 + imm;
      return {s[31:1], 1'b0};
    end
    return m_pc + imm;
  endfunction

  task automatic m_bump();
    m_cnt  = (m_cnt  >= 65535) ? 65535 : m_cnt + 1;
    m_cnt2 = (m_cnt2 >= 3)     ? 3     : m_cnt2 + 1;
  endtask

  task automatic model_clock();
    logic [31:0] t;
    bit tk, trp;
    tk  = m_taken();
    t   = m_target();
    trp = tk && (t[1:0] != 2'b00);
    if (reset) begin
      m_pc = RST_PC; m_hold = 0; m_buf_trap = 0; m_mis = 0; m_cnt = 0; m_cnt2 = 0;
    end else if (m_hold) begin
      m_mis = 0;
      if (!stall) begin
        m_pc = m_buf_pc; m_mis = m_buf_trap; m_hold = 0;
        if (!m_buf_trap) m_bump();
      end
    end else if (stall) begin
      m_mis = 0;
      if (tk) begin
        m_hold = 1; m_buf_trap = trp; m_buf_pc = trp ? TRP_PC : t;
      end
    end else begin
      m_mis = trp;
      if (trp) m_pc = TRP_PC;
      else if (tk) begin m_pc = t; m_bump(); end
      else m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; stall = 0; branch = 0; branch_op = 3'd0; jump = 0; jalr = 0;
    zero = 0; lt = 0; ltu = 0; imm = 32'd0; rs1 = 32'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic advance(input int n);
    clear_inputs();
    repeat (n) tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; stall = 1; jump = 1; imm = 32'd8;
    tick();
    tick();
    checks++; if (pc !== RST_PC) $display("FAIL reset_pc: got %h want %h", pc, RST_PC); else passes++;
    checks++; if (pending !== 1'b0) $display("FAIL reset_pending: got %b want 0", pending); else passes++;
    checks++; if (misaligned !== 1'b0) $display("FAIL reset_mis: got %b want 0", misaligned); else passes++;
    checks++; if (taken_count !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", taken_count); else passes++;
    checks++; if (count_b !== 2'd0) $display("FAIL reset_cnt_b: got %0d want 0", count_b); else passes++;
    clear_inputs();
    #1;
    checks++; if (pc_plus4 !== 32'h4) $display("FAIL seq_pc_plus4: got %h want 4", pc_plus4); else passes++;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (pc !== 32'(4 * i)) $display("FAIL seq_pc%0d: got %h want %h", i, pc, 32'(4 * i));
      else passes++;
    end
    checks++; if (taken_count !== 16'd0) $display("FAIL seq_cnt: got %0d want 0", taken_count); else passes++;
  endtask

  task automatic test_branch();
    do_reset();
    advance(2);
    checks++; if (pc !== 32'h8) $display("FAIL br_start: got %h want 8", pc); else passes++;
    branch = 1; branch_op = 3'b000; zero = 1; imm = 32'd16;
    #1;
    checks++; if (taken !== 1'b1) $display("FAIL beq_taken: got %b want 1", taken); else passes++;
    tick();
    checks++; if (pc !== 32'h18) $display("FAIL beq_pc: got %h want 18", pc); else passes++;
    checks++; if (taken_count !== 16'd1) $display("FAIL beq_cnt: got %0d want 1", taken_count); else passes++;
    do_reset();
    advance(2);
    branch = 1; branch_op = 3'b001; zero = 1; imm = 32'd16;
    #1;
    checks++; if (taken !== 1'b0) $display("FAIL bne_taken: got %b want 0", taken); else passes++;
    tick();
    checks++; if (pc !== 32'hC) $display("FAIL bne_pc: got %h want c", pc); else passes++;
  endtask

  task automatic test_jalr();
    clear_inputs();
    jalr = 1; rs1 = 32'h101; imm = 32'd3;
    tick();
    checks++; if (pc !== 32'h104) $display("FAIL jalr_pc: got %h want 104", pc); else passes++;
    jump = 1; rs1 = 32'h200; imm = 32'd8;
    tick();
    checks++; if (pc !== 32'h208) $display("FAIL jalr_prio: got %h want 208", pc); else passes++;
    checks++; if (taken_count !== 16'd2) $display("FAIL jalr_cnt: got %0d want 2", taken_count); else passes++;
  endtask

  task automatic test_misaligned();
    do_reset();
    advance(4);
    jump = 1; imm = 32'd6;
    tick();
    checks++; if (pc !== TRP_PC) $display("FAIL trap_pc: got %h want %h", pc, TRP_PC); else passes++;
    checks++; if (misaligned !== 1'b1) $display("FAIL trap_pulse: got %b want 1", misaligned); else passes++;
    checks++; if (taken_count !== 16'd0) $display("FAIL trap_cnt: got %0d want 0", taken_count); else passes++;
    clear_inputs();
    tick();
    checks++; if (misaligned !== 1'b0) $display("FAIL trap_pulse_end: got %b want 0", misaligned); else passes++;
    checks++; if (pc !== 32'h104) $display("FAIL trap_next: got %h want 104", pc); else passes++;
  endtask

  task automatic test_stall_hold();
    do_reset();
    advance(8);
    checks++; if (pc !== 32'h20) $display("FAIL hold_start: got %h want 20", pc); else passes++;
    stall = 1; branch = 1; branch_op = 3'b100; lt = 1; imm = 32'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'h20) $display("FAIL hold_pc%0d: got %h want 20", i, pc); else passes++;
      checks++; if (pending !== 1'b1) $display("FAIL hold_pend%0d: got %b want 1", i, pending); else passes++;
    end
    clear_inputs();
    tick();
    checks++; if (pc !== 32'h60) $display("FAIL hold_apply: got %h want 60", pc); else passes++;
    checks++; if (pending !== 1'b0) $display("FAIL hold_release: got %b want 0", pending); else passes++;
    checks++; if (taken_count !== 16'd1) $display("FAIL hold_cnt: got %0d want 1", taken_count); else passes++;
    do_reset();
    advance(8);
    stall = 1; branch = 1; branch_op = 3'b100; lt = 1; imm = 32'h40;
    tick();
    tick();
    reset = 1;
    tick();
    checks++; if (pc !== RST_PC) $display("FAIL hold_reset_pc: got %h want %h", pc, RST_PC); else passes++;
    checks++; if (pending !== 1'b0) $display("FAIL hold_reset_pend: got %b want 0", pending); else passes++;
    clear_inputs();
    tick();
    checks++; if (pc !== 32'h4) $display("FAIL hold_reset_after: got %h want 4", pc); else passes++;
  endtask

  task automatic test_saturation();
    do_reset();
    clear_inputs();
    jump = 1; imm = 32'd8;
    repeat (5) tick();
    checks++; if (count_b !== 2'd3) $display("FAIL sat_cnt2: got %0d want 3", count_b); else passes++;
    checks++; if (taken_count !== 16'd5) $display("FAIL sat_cnt16: got %0d want 5", taken_count); else passes++;
    checks++; if (pc_b !== 32'd40) $display("FAIL sat_pc: got %h want 28", pc_b); else passes++;
  endtask

  task automatic test_random();
    logic [31:0] r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom % 40) == 0;
      stall     = ($urandom % 3) == 0;
      branch    = $urandom % 2;
      branch_op = 3'($urandom);
      jump      = ($urandom % 5) == 0;
      jalr      = ($urandom % 6) == 0;
      zero      = $urandom % 2;
      lt        = $urandom % 2;
      ltu       = $urandom % 2;
      r         = $urandom_range(0, 255) - 32'd128;
      imm       = (($urandom % 8) == 0) ? r : (r & 32'hFFFF_FFFC);
      rs1       = $urandom & 32'h0000_0FFF;
      #1;
      checks++; if (taken !== m_taken()) $display("FAIL rnd_taken[%0d]: got %b want %b", i, taken, m_taken()); else passes++;
      checks++; if (pc_plus4 !== m_pc + 32'd4) $display("FAIL rnd_pc4[%0d]: got %h want %h", i, pc_plus4, m_pc + 32'd4); else passes++;
      checks++;
      if ({taken_b, pc_plus4_b} !== {m_taken(), m_pc + 32'd4})
        $display("FAIL rnd_comb_b[%0d]: got %b/%h want %b/%h", i, taken_b, pc_plus4_b, m_taken(), m_pc + 32'd4);
      else passes++;
      tick();
      checks++; if (pc !== m_pc) $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc, m_pc); else passes++;
      checks++; if (pending !== m_hold) $display("FAIL rnd_pend[%0d]: got %b want %b", i, pending, m_hold); else passes++;
      checks++; if (misaligned !== m_mis) $display("FAIL rnd_mis[%0d]: got %b want %b", i, misaligned, m_mis); else passes++;
      checks++; if (taken_count !== 16'(m_cnt)) $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, taken_count, m_cnt); else passes++;
      checks++;
      if ({pc_b, pending_b, misaligned_b, count_b} !== {m_pc, m_hold, m_mis, 2'(m_cnt2)})
        $display("FAIL rnd_b[%0d]: got %h/%b/%b/%0d want %h/%b/%b/%0d", i,
                 pc_b, pending_b, misaligned_b, count_b, m_pc, m_hold, m_mis, m_cnt2);
      else passes++;
    end
  endtask

  initial begin
    m_pc = RST_PC; m_buf_pc = '0; m_hold = 0; m_buf_trap = 0; m_mis = 0; m_cnt = 0; m_cnt2 = 0;
    clear_inputs();
    test_reset();
    test_branch();
    test_jalr();
    test_misaligned();
    test_stall_hold();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the RISC-V datapath: owns the PC register and selects the next PC from sequential increment, conditional branch, JAL or JALR targets. Extends the plain branch&zero next-PC select with full B-type condition decoding, stall handling with a one-entry pending redirect, misaligned-target trapping and a saturating taken-branch counter. Sits between the control unit/ALU flags and the instruction memory address port.

## Interface

Parameters:
- XLEN, 32, PC and operand width
- RESET_PC, 32'h0000_0000, PC value after reset
- TRAP_PC, 32'h0000_0100, PC loaded on misaligned target
- CNT_W, 16, width of taken-branch counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC this cycle
- branch  in  1  B-type instruction in flight
- branch_op  in  3  funct3 condition: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111
- jump  in  1  JAL
- jalr  in  1  JALR
- zero  in  1  ALU result zero
- lt  in  1  signed rs1<rs2 from ALU
- ltu  in  1  unsigned rs1<rs2 from ALU
- imm  in  XLEN  sign-extended immediate
- rs1  in  XLEN  register operand for JALR
- pc  out  XLEN  current PC (registered)
- pc_plus4  out  XLEN  pc+4 (combinational, link value)
- taken  out  1  redirect decided this cycle (combinational)
- misaligned  out  1  registered one-cycle pulse: trap taken
- pending  out  1  redirect buffered while stalled
- taken_count  out  CNT_W  saturating count of applied redirects

## Operation

- Condition: cond = BEQ zero, BNE !zero, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu; codes 010/011 → cond=0.
- Priority: jalr > jump > (branch & cond). taken = any of these.
- Target: jalr → (rs1+imm) & ~1; jump/branch → pc+imm. Sums wrap modulo 2^XLEN.
- Misaligned: taken and target[1:0]≠0 → trap; PC loads TRAP_PC instead of target.
- FSM states RUN, HOLD:
  - RUN, stall=0: pc ← trap ? TRAP_PC : taken ? target : pc+4.
  - RUN, stall=1, taken=0: pc holds, stay RUN.
  - RUN, stall=1, taken=1: pc holds; latch next value (target or TRAP_PC) and trap flag into pending register; → HOLD.
  - HOLD, stall=1: pc holds; new decisions ignored.
  - HOLD, stall=0: pc ← pending value; misaligned pulses if latched trap; → RUN. Current-cycle inputs ignored.
- taken_count increments by 1 on every applied non-trap redirect; saturates at 2^CNT_W−1.
- Reset (any state, including HOLD): pc=RESET_PC, state RUN, pending=0, misaligned=0, taken_count=0.

## Timing

- pc updates on rising clk edge; one-cycle latency from inputs to pc.
- taken, pc_plus4 combinational from current pc and inputs; no registered outputs besides pc, misaligned, pending, taken_count.
- misaligned asserted exactly the cycle pc==TRAP_PC after trap load.
- pending high for the whole HOLD state; falls the edge the buffered value is applied.
- Reset takes priority over stall and redirect in the same cycle.

## Structure

- Package riscv_pc_pkg: branch_op localparams (BEQ…BGEU), FSM state enum {RUN, HOLD}.
- Sub-module branch_cond: combinational decode of branch_op/zero/lt/ltu → cond.
- Top: target adders, priority select, FSM, pending register, counter.

## Test plan

- Reset held 2 cycles, release, stall=0, no branch → pc 0x0, 0x4, 0x8, 0xC; taken_count=0.
- pc=0x8, branch=1, BEQ, zero=1, imm=16 → next pc=0x18, taken_count=1; same with BNE → pc=0xC.
- jalr=1, rs1=0x101, imm=3 → pc=0x104; jalr with jump=1 simultaneously → jalr target wins.
- pc=0x10, jump=1, imm=6 → pc=TRAP_PC (0x100), misaligned pulse 1 cycle, taken_count unchanged.
- pc=0x20, stall=1 with BLT lt=1 imm=0x40 for 3 cycles → pc holds 0x20, pending=1; stall drops (inputs now no-branch) → pc=0x60, pending=0; reset asserted mid-HOLD instead → pc=RESET_PC, pending=0.
- CNT_W=2, 5 taken branches → taken_count stops at 3.
